// File: rtl/led_matrix_pkg.sv
// Shared dot-matrix geometry and row-pattern type, used by the scan driver and the pattern generator.
package led_matrix_pkg;

    localparam int ROWS  = 5;
    localparam int COLS  = 7;
    localparam int ROW_W = 3;

    typedef logic [COLS-1:0] row_pattern_t;

endpackage

// File: rtl/row_scan_timer.sv
// Per-row dwell counter and row index for the matrix scan; both clear while the scan is disabled.
module row_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = 5,
    parameter int DWELL = 16384,
    parameter int DW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             en,
    output logic [DW-1:0]    dcnt,
    output logic [ROW_W-1:0] ridx,
    output logic             row_end,
    output logic             frame_end
);

    assign row_end   = en && (dcnt == DW'(DWELL - 1));
    assign frame_end = row_end && (ridx == ROW_W'(ROWS - 1));

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
            ridx <= '0;
        end else if (!en) begin
            dcnt <= '0;
            ridx <= '0;
        end else if (row_end) begin
            dcnt <= '0;
            ridx <= frame_end ? '0 : ridx + 1'b1;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_frame_scan.sv
// Double-buffered 5x7 LED frame store with frame-aligned bank swap and registered row/column scan.
// Optional macro LED_BLANK_EN forces columns off for the first BLANK cycles of every row dwell.
module led_frame_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = 5,
    parameter int COLS  = 7,
    parameter int DWELL = 16384,
    parameter int BLANK = 64
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             frame_start,
    output logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  column
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [COLS-1:0]  bank [2][ROWS];
    logic             front;
    logic             pend;
    logic [DW-1:0]    dcnt;
    logic [ROW_W-1:0] ridx;
    logic             row_end;
    logic             frame_end;
    logic             swap_want;
    logic             swap_now;
    logic             blank_now;
    logic             unused_sigs;

    row_scan_timer #(
        .ROWS  (ROWS),
        .DWELL (DWELL),
        .DW    (DW)
    ) u_timer (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .en        (en),
        .dcnt      (dcnt),
        .ridx      (ridx),
        .row_end   (row_end),
        .frame_end (frame_end)
    );

`ifdef LED_BLANK_EN
    assign blank_now   = (dcnt < DW'(BLANK));
    assign unused_sigs = row_end;
`else
    assign blank_now   = 1'b0;
    assign unused_sigs = ^{dcnt, row_end, BLANK[0]};
`endif

    // A disabled scan has no frame boundary to wait for, so a swap goes through at once.
    assign swap_want = pend || swap_req;
    assign swap_now  = swap_want && (frame_end || !en);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            front    <= 1'b0;
            pend     <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap_now;
            if (swap_now) begin
                front <= ~front;
                pend  <= 1'b0;
            end else begin
                pend  <= swap_want;
            end
        end
    end

    // Writes target the bank that is back before this edge, so a coincident swap publishes them.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
        end else if (wr_en && (wr_row < ROW_W'(ROWS))) begin
            bank[~front][wr_row] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            row         <= '0;
            column      <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            row         <= '0;
            column      <= '0;
            frame_start <= 1'b0;
        end else begin
            row         <= ROWS'(1) << ridx;
            column      <= blank_now ? '0 : bank[front][ridx];
            frame_start <= (dcnt == '0) && (ridx == '0);
        end
    end

endmodule

// File: tb/tb_led_frame_scan.sv
// Directed bench for led_frame_scan at DWELL=8, BLANK=2; expected column data follows LED_BLANK_EN.
module tb_led_frame_scan;
    import led_matrix_pkg::*;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * DWELL;
`ifdef LED_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic             CLOCK_50 = 1'b0;
    logic             rst;
    logic             en;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COLS-1:0]  wr_data;
    logic             swap_req;
    logic             swap_ack;
    logic             frame_start;
    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  column;

    int checks = 0;
    int errors = 0;

    row_pattern_t disp [ROWS];

    led_frame_scan #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .row         (row),
        .column      (column)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [ROWS-1:0] exp_row(int k);
        return ROWS'(1) << (((k - 1) % FRAME) / DWELL);
    endfunction

    function automatic logic [COLS-1:0] exp_col(int k);
        if (BLANK_ON && (((k - 1) % DWELL) < BLANK)) return '0;
        return disp[((k - 1) % FRAME) / DWELL];
    endfunction

    function automatic logic exp_fs(int k);
        return ((k - 1) % FRAME) == 0;
    endfunction

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_disp(input logic [COLS-1:0] r0, input logic [COLS-1:0] r2);
        for (int i = 0; i < ROWS; i++) disp[i] = '0;
        disp[0] = r0;
        disp[2] = r2;
    endtask

    task automatic restart;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        en       = 1'b0;
        tick();
        en       = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++; if (row !== '0) begin errors++; $display("[TB] FAIL reset_row: got %b expected 0", row); end
        checks++; if (column !== '0) begin errors++; $display("[TB] FAIL reset_column: got %h expected 0", column); end
        checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_swap_ack: got %b expected 0", swap_ack); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scan;
        set_disp('0, '0);
        en = 1'b1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            tick();
            checks++; if (row !== exp_row(k)) begin errors++; $display("[TB] FAIL scan_row c%0d: got %b expected %b", k, row, exp_row(k)); end
            checks++; if (column !== '0) begin errors++; $display("[TB] FAIL scan_column c%0d: got %h expected 0", k, column); end
            checks++; if (frame_start !== exp_fs(k)) begin errors++; $display("[TB] FAIL scan_frame_start c%0d: got %b expected %b", k, frame_start, exp_fs(k)); end
        end
    endtask

    task automatic test_swap;
        restart();
        for (int k = 1; k <= 2 * FRAME; k++) begin
            wr_en = (k == 1); wr_row = 3'd2; wr_data = 7'h55; swap_req = (k == 3);
            tick();
            checks++; if (swap_ack !== (k == FRAME)) begin errors++; $display("[TB] FAIL swap_ack c%0d: got %b expected %b", k, swap_ack, (k == FRAME)); end
            checks++; if (column !== exp_col(k)) begin errors++; $display("[TB] FAIL swap_column c%0d: got %h expected %h", k, column, exp_col(k)); end
            checks++; if (frame_start !== exp_fs(k)) begin errors++; $display("[TB] FAIL swap_frame_start c%0d: got %b expected %b", k, frame_start, exp_fs(k)); end
            if (k == FRAME) set_disp('0, 7'h55);
        end
        wr_en = 1'b0; swap_req = 1'b0;
    endtask

    task automatic test_hidden_write;
        restart();
        for (int k = 1; k <= 3 * FRAME; k++) begin
            wr_en = (k == 1); wr_row = 3'd0; wr_data = 7'h7F;
            tick();
            checks++; if (column !== exp_col(k)) begin errors++; $display("[TB] FAIL hidden_column c%0d: got %h expected %h", k, column, exp_col(k)); end
            checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL hidden_swap_ack c%0d: got %b expected 0", k, swap_ack); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acks;
        acks = 0;
        restart();
        for (int k = 1; k <= FRAME + DWELL; k++) begin
            swap_req = (k == 2) || (k == 10) || (k == 20);
            tick();
            if (swap_ack === 1'b1) acks++;
            checks++; if (swap_ack !== (k == FRAME)) begin errors++; $display("[TB] FAIL merge_swap_ack c%0d: got %b expected %b", k, swap_ack, (k == FRAME)); end
            checks++; if (column !== exp_col(k)) begin errors++; $display("[TB] FAIL merge_column c%0d: got %h expected %h", k, column, exp_col(k)); end
            if (k == FRAME) set_disp(7'h7F, '0);
        end
        swap_req = 1'b0;
        checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL merge_ack_count: got %0d expected 1", acks); end
    endtask

    task automatic test_bad_row;
        restart();
        for (int k = 1; k <= 2 * FRAME; k++) begin
            wr_en = (k == 1) || (k == 2); wr_row = (k == 1) ? 3'd5 : 3'd7; wr_data = 7'h2A;
            swap_req = (k == 3);
            tick();
            checks++; if (swap_ack !== (k == FRAME)) begin errors++; $display("[TB] FAIL badrow_swap_ack c%0d: got %b expected %b", k, swap_ack, (k == FRAME)); end
            checks++; if (column !== exp_col(k)) begin errors++; $display("[TB] FAIL badrow_column c%0d: got %h expected %h", k, column, exp_col(k)); end
            if (k == FRAME) set_disp('0, 7'h55);
        end
        wr_en = 1'b0; swap_req = 1'b0;
    endtask

    task automatic test_disable;
        int acks;
        acks = 0;
        restart();
        for (int k = 1; k <= 28; k++) begin
            tick();
            checks++; if (row !== exp_row(k)) begin errors++; $display("[TB] FAIL dis_row c%0d: got %b expected %b", k, row, exp_row(k)); end
        end
        en = 1'b0;
        tick();
        checks++; if (row !== '0) begin errors++; $display("[TB] FAIL dis_row_dark: got %b expected 0", row); end
        checks++; if (column !== '0) begin errors++; $display("[TB] FAIL dis_column_dark: got %h expected 0", column); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL dis_frame_start_dark: got %b expected 0", frame_start); end
        swap_req = 1'b1;
        tick();
        if (swap_ack === 1'b1) acks++;
        swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (swap_ack === 1'b1) acks++;
            checks++; if (row !== '0) begin errors++; $display("[TB] FAIL dis_row_hold %0d: got %b expected 0", i, row); end
        end
        checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL dis_swap_ack_count: got %0d expected 1", acks); end
        set_disp(7'h7F, '0);
        en = 1'b1;
        tick();
        checks++; if (row !== 5'b00001) begin errors++; $display("[TB] FAIL dis_resume_row: got %b expected 00001", row); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL dis_resume_frame_start: got %b expected 1", frame_start); end
        checks++; if (column !== exp_col(1)) begin errors++; $display("[TB] FAIL dis_resume_column: got %h expected %h", column, exp_col(1)); end
    endtask

    task automatic test_reset_pending;
        restart();
        for (int k = 1; k <= 10; k++) begin
            swap_req = (k == 5);
            tick();
        end
        swap_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (row !== '0) begin errors++; $display("[TB] FAIL rstmid_row: got %b expected 0", row); end
        checks++; if (column !== '0) begin errors++; $display("[TB] FAIL rstmid_column: got %h expected 0", column); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_frame_start: got %b expected 0", frame_start); end
        tick();
        rst = 1'b0;
        set_disp('0, '0);
        for (int k = 1; k <= FRAME + DWELL; k++) begin
            tick();
            checks++; if (swap_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_swap_ack c%0d: got %b expected 0", k, swap_ack); end
            checks++; if (row !== exp_row(k)) begin errors++; $display("[TB] FAIL rstmid_row c%0d: got %b expected %b", k, row, exp_row(k)); end
            checks++; if (column !== exp_col(k)) begin errors++; $display("[TB] FAIL rstmid_column c%0d: got %h expected %h", k, column, exp_col(k)); end
            checks++; if (frame_start !== exp_fs(k)) begin errors++; $display("[TB] FAIL rstmid_frame_start c%0d: got %b expected %b", k, frame_start, exp_fs(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_swap();
        test_hidden_write();
        test_back_to_back();
        test_bad_row();
        test_disable();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_frame_scan.md
# led_frame_scan

Double-buffered 5×7 LED dot-matrix frame store and scan driver. It accepts row-wide pixel writes from an upstream pattern source into a back bank. It swaps banks only at frame boundaries, so a frame is never half-updated. It time-multiplexes the front bank onto the matrix `row`/`column` pins at a fixed per-row dwell. It sits between the pattern/character generator and the matrix pins, and replaces free-running test scanning with content-driven display.

## Interface
Parameters:
- `ROWS`, 5: matrix rows.
- `COLS`, 7: matrix columns (pixel bits per row).
- `DWELL`, 16384: `CLOCK_50` cycles each row is driven; must be ≥ 2.
- `BLANK`, 64: leading cycles of each dwell with columns forced off; used only under `LED_BLANK_EN`, and must be < `DWELL`.

Ports:
- `CLOCK_50` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable. When it is 0, scanning stops and the outputs go dark.
- `wr_en` in 1: write strobe into the back bank.
- `wr_row` in 3: row address for the write.
- `wr_data` in `COLS`: pixel bits for the row; bit c is column c; 1 = lit.
- `swap_req` in 1: single-cycle request to publish the back bank.
- `swap_ack` out 1: one-cycle pulse on the cycle the banks swap.
- `frame_start` out 1: one-cycle pulse when row 0 begins its dwell.
- `row` out `ROWS`: one-hot, active-high row select.
- `column` out `COLS`: active-high column drive.

## Operation
Storage and writes:
- Two banks, each `ROWS`×`COLS` bits. Bank select `front` is 0 after reset. The back bank is `~front`.
- Writes with `wr_en=1` go to `back[wr_row]`. Writes with `wr_row ≥ ROWS` are ignored.
- Writes are accepted whether `en` is 0 or 1.

Scan:
- Counter `dcnt` runs 0..`DWELL`-1. Row index `ridx` runs 0..`ROWS`-1.
- When `dcnt=DWELL-1`, `dcnt` wraps to 0 and `ridx` increments, wrapping from `ROWS-1` to 0.
- Frame boundary: the cycle with `dcnt=DWELL-1` and `ridx=ROWS-1`.

Swap:
- A `swap_req` pulse sets `pend`. Further requests while `pend=1` merge into the same swap.
- At the frame boundary with `pend` (or `swap_req`) set, the block toggles `front`, clears `pend`, and pulses `swap_ack`.
- When `en=0`, a pending swap executes on the next cycle.
- If a write and a swap land in the same cycle, the write goes into the pre-swap back bank and is displayed immediately after the swap.
- The new back bank keeps stale content. The upstream source must rewrite every row it needs to change.

Disable:
- When `en=0`, `dcnt`, `ridx`, `row`, `column`, and `frame_start` are forced to 0 on the next edge.
- Bank contents and `front` are preserved.

## Timing
- Reset values:
  - `row=0`, `column=0`, `swap_ack=0`, `frame_start=0`.
  - `dcnt=0`, `ridx=0`, `pend=0`, `front=0`.
  - Both banks all zero.
- All outputs are registered. `row`/`column` reflect the `dcnt`/`ridx` state of the previous cycle (1-cycle latency).
- First edge with `en=1` after reset: `row=5'b00001`, `column=front[0]`, `frame_start=1`.
- `frame_start` recurs every `ROWS·DWELL` cycles.
- `row` changes exactly every `DWELL` cycles.
- A `swap_req` issued in cycle t is acknowledged at the next frame boundary, at most `ROWS·DWELL` cycles later.
- New content appears on `column` the cycle after `swap_ack`, together with `frame_start`.
- `swap_ack` and `frame_start` are each exactly 1 cycle wide.
- Reset asserted mid-frame clears everything asynchronously, including `pend`. An outstanding request is therefore lost.

## Configuration
- `LED_BLANK_EN` defined: `column=0` while `dcnt<BLANK` within each dwell. `row` is still driven, so ghosting is suppressed at row transitions.
- `LED_BLANK_EN` undefined: `column=front[ridx]` for the full dwell, and the `BLANK` parameter is unused.

## Structure
- Package `led_matrix_pkg`: `ROWS`, `COLS`, `ROW_W=3`, and the row-pattern typedef `logic [COLS-1:0]`. The pattern generator shares this package.
- Sub-module `row_scan_timer` holds `dcnt`/`ridx` and `en` clearing. It emits `row_end`, `frame_end`, and the current `ridx`.
- The top level holds the banks, the swap logic, and the output registers.

## Test plan
Run with `DWELL=8`, `BLANK=2`.
- Reset, then `en=1` for 40 cycles → `row` steps 00001→00010→…→10000→00001 every 8 cycles; `column=0`; `frame_start` pulses at cycles 1 and 41.
- Write row 2 = 7'h55, `swap_req` at cycle 3 → `swap_ack` at cycle 40; during the row-2 dwell of the next frame, `column=7'h55`.
- Write row 0 = 7'h7F without a swap → the display is unchanged over 3 frames.
- `swap_req` three times within one frame → exactly one `swap_ack`.
- Write `wr_row=5`, then swap → no bank content changes.
- `en` dropped mid-row 3 → outputs go to 0 the next cycle; `en` re-raised → `row=00001`, `frame_start=1`.
- `rst` pulsed mid-frame with `pend=1` → all outputs go to 0 and no `swap_ack` follows.
- With `LED_BLANK_EN`: first 2 cycles of each dwell `column=0`, the remaining 6 cycles show pattern data.
